implication_sweep_checker: RTL
==============================

// Module: implication_sweep_checker
// PURPOSE
//  Response side of the two-input implication exercise. Drives x,y through
//  all four vectors (00,01,10,11) and samples two DUT outputs:
//  a_in must equal ~x|y (x->y), b_in must equal x|~y (y->x). Scores every
//  vector and reports pass/fail, mismatch count and failing-vector map.
//  Sits between a start source and the two implication gates under test.
// PARAMETERS
//  SETTLE  1  cycles waited after driving x,y before sampling (0..255)
//  PASSES  1  number of full 4-vector sweeps per start (>=1)
//  ERR_W   4  width of err_cnt
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous reset, active low
//  start     in   1      level sampled each edge; launches a run when idle
//  x         out  1      stimulus to DUT (registered)
//  y         out  1      stimulus to DUT (registered)
//  a_in      in   1      DUT output expected ~x|y
//  b_in      in   1      DUT output expected x|~y
//  busy      out  1      high from first DRIVE cycle through DONE
//  done      out  1      one-cycle pulse at end of run
//  pass      out  1      1 = last run had zero mismatches; held until next start
//  err_cnt   out  ERR_W  mismatching vector samples, last run, saturating
//  fail_vec  out  4      bit v set if vector v={x,y} ever mismatched in run
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; x=y=0; busy=done=pass=0; err_cnt=0;
//   fail_vec=0; internal vec, settle and pass counters = 0. Applies
//   immediately, including mid-run; no done pulse for an aborted run.
//  FSM: IDLE -> DRIVE -> SETTLE -> SAMPLE -> (DRIVE | DONE) -> IDLE.
//  IDLE: start=1 at an edge -> DRIVE; clears err_cnt, fail_vec, pass, vec=0,
//   pass counter=0. start=0 -> stay.
//  DRIVE (1 cycle): x<=vec[1], y<=vec[0]; load settle counter with SETTLE.
//   SETTLE=0 -> go SAMPLE directly, else -> SETTLE.
//  SETTLE: decrement each cycle; leave for SAMPLE on the cycle it hits 0
//   (exactly SETTLE cycles spent here).
//  SAMPLE (1 cycle): exp_a=~x|y, exp_b=x|~y. Mismatch = (a_in!=exp_a) |
//   (b_in!=exp_b); counts once per vector even if both wrong. On mismatch:
//   err_cnt+1 saturating at 2^ERR_W-1; fail_vec[vec]<=1 (OR across passes).
//   vec<3 -> vec+1, DRIVE. vec==3 and pass counter<PASSES-1 -> vec=0,
//   pass counter+1, DRIVE. Otherwise -> DONE.
//  DONE (1 cycle): done=1; pass<=(err_cnt==0) using the final count; -> IDLE.
//  Latency: start seen at edge k -> busy from cycle k+1; done high in cycle
//   k+1+(2+SETTLE)*4*PASSES. SETTLE=1, PASSES=1 -> done at k+13.
//  start while busy ignored (no restart, no queueing). start held high
//   through DONE relaunches a run on the edge after DONE (back-to-back).
//  x,y hold the last vector (11) after DONE until next run or reset.
//  err_cnt/fail_vec/pass hold their values in IDLE until next start.
//  a_in/b_in are sampled only in SAMPLE; other cycles don't care.
// TESTING
//  1 Correct DUT, SETTLE=1, PASSES=1, start pulse -> x,y = 00,01,10,11;
//    done at start edge+13; pass=1, err_cnt=0, fail_vec=4'b0000.
//  2 b_in tied to a_in -> mismatches on vectors 01,10 -> err_cnt=2,
//    fail_vec=4'b0110, pass=0.
//  3 a_in stuck 0, PASSES=3 -> err_cnt=9, fail_vec=4'b1011; same with
//    ERR_W=3 -> err_cnt saturates at 7.
//  4 start re-pulsed while busy at vec=2 -> ignored; exactly one done pulse,
//    result identical to scenario 1.
//  5 rst_n low mid-SETTLE of vec=1 -> x=y=0, busy=0, err_cnt=0 without clock
//    edge; no done; next start runs full clean sweep.
//  6 SETTLE=0, correct DUT -> each vector 2 cycles, done at start edge+9;
//    start held high -> second run starts edge after DONE.

Source files
------------

// File: rtl/implication_sweep_checker_if.sv
// Bundle between the implication sweep checker and its start source / gates under test.
// The checker takes the master side; the environment takes the slave side.
interface implication_sweep_checker_if #(
  parameter int ERR_W = 4
);
  logic             start;
  logic             x;
  logic             y;
  logic             a_in;
  logic             b_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [3:0]       fail_vec;

  modport master (
    input  start, a_in, b_in,
    output x, y, busy, done, pass, err_cnt, fail_vec
  );

  modport slave (
    output start, a_in, b_in,
    input  x, y, busy, done, pass, err_cnt, fail_vec
  );
endinterface

// File: rtl/implication_sweep_checker.sv
// Sweeps x,y through 00..11, checks a_in == x->y and b_in == y->x after a settle
// delay, and reports pass flag, saturating mismatch count and failing-vector map.
module implication_sweep_checker #(
  parameter int SETTLE = 1,
  parameter int PASSES = 1,
  parameter int ERR_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  implication_sweep_checker_if.master   bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  logic [2:0]       r_state;
  logic [1:0]       r_vec;
  logic [7:0]       r_settle;
  logic [PC_W-1:0]  r_pcnt;
  logic             r_x;
  logic             r_y;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [3:0]       r_fvec;

  logic             w_exp_a;
  logic             w_exp_b;
  logic             w_mis;
  logic             w_last_pass;

  // A vector counts once even when both responses are wrong
  assign w_exp_a     = ~r_x | r_y;
  assign w_exp_b     = r_x | ~r_y;
  assign w_mis       = (bus.a_in != w_exp_a) | (bus.b_in != w_exp_b);
  assign w_last_pass = (r_pcnt == PC_W'(PASSES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_vec    <= 2'd0;
      r_settle <= 8'd0;
      r_pcnt   <= '0;
      r_x      <= 1'b0;
      r_y      <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_fvec   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_DRIVE;
            r_err   <= '0;
            r_fvec  <= 4'd0;
            r_pass  <= 1'b0;
            r_vec   <= 2'd0;
            r_pcnt  <= '0;
          end
        end
        S_DRIVE: begin
          r_x      <= r_vec[1];
          r_y      <= r_vec[0];
          r_settle <= 8'(SETTLE);
          r_state  <= (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
        end
        S_SETTLE: begin
          // Exit when the count reaches zero, giving exactly SETTLE cycles here
          r_settle <= r_settle - 8'd1;
          if (r_settle <= 8'd1) begin
            r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (w_mis) begin
            r_err         <= sat_inc(r_err);
            r_fvec[r_vec] <= 1'b1;
          end
          if (r_vec != 2'd3) begin
            r_vec   <= r_vec + 2'd1;
            r_state <= S_DRIVE;
          end else if (!w_last_pass) begin
            r_vec   <= 2'd0;
            r_pcnt  <= r_pcnt + PC_W'(1);
            r_state <= S_DRIVE;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_pass  <= (r_err == '0);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.x        = r_x;
  assign bus.y        = r_y;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.pass     = r_pass;
  assign bus.err_cnt  = r_err;
  assign bus.fail_vec = r_fvec;

endmodule
